// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the stack-processor ALU.
//   alu_op_e    - 4-bit opcode encoding (ALU_ADD..ALU_EQ, ALU_RSVD), also
//                 intended for use by the control unit.
//   shift_mode_e - shift kind selector for alu_shifter.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_NOR   = 4'd5,
      ALU_SLL   = 4'd6,
      ALU_SRL   = 4'd7,
      ALU_SRA   = 4'd8,
      ALU_SLT   = 4'd9,
      ALU_SLTU  = 4'd10,
      ALU_PASSA = 4'd11,
      ALU_PASSB = 4'd12,
      ALU_NOT   = 4'd13,
      ALU_EQ    = 4'd14,
      ALU_RSVD  = 4'd15
   } alu_op_e;

   typedef enum logic [1:0] {
      SH_LL = 2'd0,
      SH_RL = 2'd1,
      SH_RA = 2'd2
   } shift_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational 16-bit shifter (SLL / SRL / SRA).
// Ports:
//   data    in   16  value to shift
//   amount  in   4   shift distance 0..15 (0 returns data unchanged)
//   mode    in   2   shift kind (shift_mode_e)
//   result  out  16  shifted value
module alu_shifter
   import alu_pkg::*;
(
   input  logic [15:0] data,
   input  logic [3:0]  amount,
   input  shift_mode_e mode,
   output logic [15:0] result
);

   always_comb begin
      result = data << amount;
      case (mode)
         SH_LL:   result = data << amount;
         SH_RL:   result = data >> amount;
         SH_RA:   result = $unsigned($signed(data) >>> amount);
         default: result = data;
      endcase
   end

endmodule

// File: rtl/alu.sv
// alu: 16-bit integer ALU for the stack processor datapath.
// Result, zero flag and signed-overflow flag are registered (1-cycle latency,
// a new operation every cycle, no handshake).
// Ports:
//   clk       in   1      system clock, rising edge
//   rst       in   1      synchronous active-high reset (r=0, zero=1, overflow=0)
//   a         in   WIDTH  operand A (minuend / left operand for SUB, SLT)
//   b         in   WIDTH  operand B (b[3:0] is the shift amount)
//   op        in   4      operation select (alu_op_e)
//   r         out  WIDTH  registered result
//   zero      out  1      registered, 1 iff r == 0
//   overflow  out  1      registered signed overflow (ADD/SUB only)
module alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic [WIDTH-1:0] r,
   output logic             zero,
   output logic             overflow
);

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] f;
   logic             f_ovf;
   shift_mode_e      sh_mode;

   assign sum  = a + b;
   assign diff = a - b;

   always_comb begin
      sh_mode = SH_RL;
      if (alu_op_e'(op) == ALU_SLL)
         sh_mode = SH_LL;
      else if (alu_op_e'(op) == ALU_SRA)
         sh_mode = SH_RA;
   end

   alu_shifter u_shifter (
      .data   (a),
      .amount (b[3:0]),
      .mode   (sh_mode),
      .result (shifted)
   );

   always_comb begin
      f     = '0;
      f_ovf = 1'b0;
      case (alu_op_e'(op))
         ALU_ADD: begin
            f     = sum;
            f_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SUB: begin
            f     = diff;
            f_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_AND:   f = a & b;
         ALU_OR:    f = a | b;
         ALU_XOR:   f = a ^ b;
         ALU_NOR:   f = ~(a | b);
         ALU_SLL,
         ALU_SRL,
         ALU_SRA:   f = shifted;
         // True signed compare, not the sign of a-b, so overflow cannot corrupt it.
         ALU_SLT:   f = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU:  f = {{(WIDTH-1){1'b0}}, (a < b)};
         ALU_PASSA: f = a;
         ALU_PASSB: f = b;
         ALU_NOT:   f = ~a;
         ALU_EQ:    f = {{(WIDTH-1){1'b0}}, (a == b)};
         default:   f = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r        <= '0;
         zero     <= 1'b1;
         overflow <= 1'b0;
      end else begin
         r        <= f;
         zero     <= (f == '0);
         overflow <= f_ovf;
      end
   end

endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu. A behavioural model computes the
// expected registered outputs from integer arithmetic; one compare process
// checks every cycle. Directed literal checks pin the model and DUT.
module tb_alu;

   logic        clk;
   logic        rst;
   logic [15:0] a;
   logic [15:0] b;
   logic [3:0]  op;
   logic [15:0] r;
   logic        zero;
   logic        overflow;

   int unsigned passed;
   int unsigned total;

   logic [15:0] exp_r;
   logic        exp_zero;
   logic        exp_ovf;
   logic        exp_valid;
   logic        running;

   alu #(.WIDTH(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .b        (b),
      .op       (op),
      .r        (r),
      .zero     (zero),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Returns {r, zero, overflow} expected after an edge with these inputs.
   function automatic logic [17:0] model(input logic rs, input logic [3:0] o,
                                         input logic [15:0] x, input logic [15:0] y);
      int sx, sy, ux, uy, res, n;
      logic ov;
      logic [15:0] rr;
      sx = int'($signed(x));
      sy = int'($signed(y));
      ux = int'(x);
      uy = int'(y);
      n  = uy % 16;
      ov = 1'b0;
      res = 0;
      if (rs) return {16'h0000, 1'b1, 1'b0};
      case (o)
         4'd0:  begin res = sx + sy; ov = (res > 32767) || (res < -32768); end
         4'd1:  begin res = sx - sy; ov = (res > 32767) || (res < -32768); end
         4'd2:  res = ux & uy;
         4'd3:  res = ux | uy;
         4'd4:  res = ux ^ uy;
         4'd5:  res = ~(ux | uy);
         4'd6:  res = ux * (1 << n);
         4'd7:  res = ux / (1 << n);
         4'd8:  res = sx >>> n;
         4'd9:  res = (sx < sy) ? 1 : 0;
         4'd10: res = (ux < uy) ? 1 : 0;
         4'd11: res = ux;
         4'd12: res = uy;
         4'd13: res = 65535 - ux;
         4'd14: res = (ux == uy) ? 1 : 0;
         default: res = 0;
      endcase
      rr = res[15:0];
      return {rr, (rr == 16'h0000), ov};
   endfunction

   always @(posedge clk) begin
      {exp_r, exp_zero, exp_ovf} <= model(rst, op, a, b);
      exp_valid <= 1'b1;
   end

   always @(negedge clk) begin
      if (exp_valid && running) begin
         total = total + 1;
         if (r === exp_r && zero === exp_zero && overflow === exp_ovf)
            passed = passed + 1;
         else
            $display("FAIL model t=%0t op=%0d: got r=%h z=%b v=%b, want r=%h z=%b v=%b",
                     $time, op, r, zero, overflow, exp_r, exp_zero, exp_ovf);
      end
   end

   task automatic drive(input logic rs, input logic [3:0] o,
                        input logic [15:0] x, input logic [15:0] y);
      @(negedge clk);
      rst = rs; op = o; a = x; b = y;
   endtask

   task automatic lit(input string name, input logic rs, input logic [3:0] o,
                      input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] er, input logic ez, input logic ev);
      drive(rs, o, x, y);
      @(posedge clk);
      #1;
      total = total + 1;
      if (r === er && zero === ez && overflow === ev)
         passed = passed + 1;
      else
         $display("FAIL %s: got r=%h z=%b v=%b, want r=%h z=%b v=%b",
                  name, r, zero, overflow, er, ez, ev);
   endtask

   initial begin
      passed = 0; total = 0;
      exp_valid = 1'b0; running = 1'b0;
      rst = 1'b1; op = 4'd0; a = '0; b = '0;

      lit("reset",      1'b1, 4'd0,  16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
      running = 1'b1;
      lit("or",         1'b0, 4'd3,  16'd64,   16'd27,   16'h005B, 1'b0, 1'b0);
      lit("add_ovf",    1'b0, 4'd0,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
      lit("sub_ovf",    1'b0, 4'd1,  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
      lit("sub_zero",   1'b0, 4'd1,  16'd5,    16'd5,    16'h0000, 1'b1, 1'b0);
      lit("eq",         1'b0, 4'd14, 16'd5,    16'd5,    16'h0001, 1'b0, 1'b0);
      lit("sll",        1'b0, 4'd6,  16'h8001, 16'd4,    16'h0010, 1'b0, 1'b0);
      lit("srl",        1'b0, 4'd7,  16'h8001, 16'd1,    16'h4000, 1'b0, 1'b0);
      lit("sra",        1'b0, 4'd8,  16'h8001, 16'd1,    16'hC000, 1'b0, 1'b0);
      lit("sll_hiamt",  1'b0, 4'd6,  16'h8001, 16'h0011, 16'h0002, 1'b0, 1'b0);
      lit("srl_hiamt",  1'b0, 4'd7,  16'h8001, 16'h0011, 16'h4000, 1'b0, 1'b0);
      lit("sra_hiamt",  1'b0, 4'd8,  16'h8001, 16'h0011, 16'hC000, 1'b0, 1'b0);
      lit("shift0",     1'b0, 4'd8,  16'h8001, 16'h0010, 16'h8001, 1'b0, 1'b0);
      lit("slt",        1'b0, 4'd9,  16'h8000, 16'h0001, 16'h0001, 1'b0, 1'b0);
      lit("sltu",       1'b0, 4'd10, 16'h8000, 16'h0001, 16'h0000, 1'b1, 1'b0);
      lit("rsvd",       1'b0, 4'd15, 16'h8000, 16'h0001, 16'h0000, 1'b1, 1'b0);
      lit("nor",        1'b0, 4'd5,  16'h00F0, 16'h0F00, 16'hF00F, 1'b0, 1'b0);
      lit("not",        1'b0, 4'd13, 16'h1234, 16'h0000, 16'hEDCB, 1'b0, 1'b0);
      lit("add_noovf",  1'b0, 4'd0,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
      lit("rst_wins",   1'b1, 4'd0,  16'd1,    16'd1,    16'h0000, 1'b1, 1'b0);

      for (int unsigned i = 0; i < 3000; i++) begin
         logic [15:0] x, y;
         x = 16'($urandom);
         y = 16'($urandom);
         case ($urandom_range(0, 3))
            0: x = 16'h8000;
            1: y = x;
            default: ;
         endcase
         drive(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)), x, y);
      end
      drive(1'b0, 4'd0, 16'd0, 16'd0);
      @(negedge clk);
      @(negedge clk);
      running = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
